// File: rtl/periph_irq_pkg.sv
// rtl/periph_irq_pkg.sv - register map and shared constants for the peripheral interrupt controller
package periph_irq_pkg;

    // Upper bound on source count; also sizes the 8-bit claim id
    localparam int MAX_SRC = 256;
    localparam int ID_W    = $clog2(MAX_SRC);

    // Per-source banks: 32 bytes apart, one 32-bit word per 32 sources
    localparam logic [7:0] REG_RAW_BASE    = 8'h00;
    localparam logic [7:0] REG_MODE_BASE   = 8'h20;
    localparam logic [7:0] REG_ENABLE_BASE = 8'h40;
    localparam logic [7:0] REG_PEND_BASE   = 8'h60;
    localparam logic [7:0] REG_STATUS_BASE = 8'h80;

    // Single-word registers
    localparam logic [7:0] REG_CLAIM       = 8'hA0;
    localparam logic [7:0] REG_COAL_CFG    = 8'hA4;
    localparam logic [7:0] REG_COAL_STAT   = 8'hA8;

    // COAL_CFG / COAL_STAT field positions
    localparam int COAL_THR_LSB = 0;
    localparam int COAL_TMO_LSB = 16;

endpackage

// File: rtl/periph_irq_prio_enc.sv
// rtl/periph_irq_prio_enc.sv - lowest-index priority encoder over the interrupt status vector
module periph_irq_prio_enc
    import periph_irq_pkg::*;
#(
    parameter int NUM_SRC = 64
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    // Scan downwards so the lowest set index is the last one written
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/periph_irq_ctrl.sv
// rtl/periph_irq_ctrl.sv - interrupt aggregation, pending/enable registers and coalesced global interrupt
module periph_irq_ctrl
    import periph_irq_pkg::*;
#(
    parameter int NUM_SRC     = 64,
    parameter int SYNC_STAGES = 2,
    parameter int APB_AW      = 8,
    parameter int APB_DW      = 32,
    parameter int CNT_W       = 8,
    parameter int TMO_W       = 16
) (
    input  logic              clk_apb,
    input  logic              rst_apb_n,
    input  logic [APB_AW-1:0] paddr,
    input  logic              pwrite,
    input  logic [APB_DW-1:0] pwdata,
    input  logic              psel,
    input  logic              penable,
    output logic [APB_DW-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [NUM_SRC-1:0] src_irq,
    output logic              irq_out,
    output logic              irq_valid,
    output logic [7:0]        irq_id
);

    localparam int NW = (NUM_SRC + 31) / 32;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [TMO_W-1:0] TMR_MAX = {TMO_W{1'b1}};

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] sync_lvl, prev_q, mode_q, enable_q, pend_q, status;
    logic [NUM_SRC-1:0] mode_d, enable_d, pend_d, status_d, w1c;
    logic [CNT_W-1:0]   thr_q, count_q;
    logic [TMO_W-1:0]   tmo_q, timer_q;
    logic [7:0]         reg_addr, bank_base;
    logic [2:0]         word;
    logic [NW*32-1:0]   bank_vec;
    logic [31:0]        rd_word;
    logic               in_bank, mapped, read_only, access, err, wr_en;
    logic               status_any, status_event, fire, enc_valid;
    logic [ID_W-1:0]    enc_id;
    logic               unused_ok;

    assign unused_ok  = ^paddr[1:0];
    assign sync_lvl   = sync_q[SYNC_STAGES-1];
    assign status     = pend_q & enable_q;
    assign status_any = |status;
    assign pready     = psel & penable;

    // Address decode, error response and read mux for the access phase
    always_comb begin
        reg_addr  = {paddr[7:2], 2'b00};
        bank_base = {paddr[7:5], 5'b0};
        word      = paddr[4:2];
        in_bank   = (reg_addr < REG_CLAIM);
        mapped    = 1'b0;
        read_only = 1'b0;
        rd_word   = '0;
        bank_vec  = '0;
        if (in_bank) begin
            mapped = (int'(word) < NW);
            case (bank_base)
                REG_RAW_BASE: begin
                    read_only                = 1'b1;
                    bank_vec[NUM_SRC-1:0]    = sync_lvl;
                end
                REG_MODE_BASE:   bank_vec[NUM_SRC-1:0] = mode_q;
                REG_ENABLE_BASE: bank_vec[NUM_SRC-1:0] = enable_q;
                REG_PEND_BASE:   bank_vec[NUM_SRC-1:0] = pend_q;
                default: begin
                    read_only                = 1'b1;
                    bank_vec[NUM_SRC-1:0]    = status;
                end
            endcase
            for (int k = 0; k < NW; k++) begin
                if (int'(word) == k) begin
                    rd_word = bank_vec[k*32 +: 32];
                end
            end
        end else begin
            case (reg_addr)
                REG_CLAIM: begin
                    mapped    = 1'b1;
                    read_only = 1'b1;
                    rd_word   = {irq_valid, 23'b0, irq_id};
                end
                REG_COAL_CFG: begin
                    mapped                          = 1'b1;
                    rd_word[COAL_THR_LSB +: CNT_W]  = thr_q;
                    rd_word[COAL_TMO_LSB +: TMO_W]  = tmo_q;
                end
                REG_COAL_STAT: begin
                    mapped                          = 1'b1;
                    read_only                       = 1'b1;
                    rd_word[COAL_THR_LSB +: CNT_W]  = count_q;
                    rd_word[COAL_TMO_LSB +: TMO_W]  = timer_q;
                end
                default: ;
            endcase
        end
        access  = psel & penable;
        err     = access & (~mapped | (pwrite & read_only));
        wr_en   = access & pwrite & ~err;
        pslverr = err;
        prdata  = (access & ~pwrite & ~err) ? rd_word : '0;
    end

    // Next-state MODE/ENABLE from writes, then PEND from the per-mode latch rule
    always_comb begin
        w1c      = '0;
        mode_d   = mode_q;
        enable_d = enable_q;
        pend_d   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (wr_en && in_bank && int'(word) == i / 32) begin
                if (bank_base == REG_MODE_BASE)   mode_d[i]   = pwdata[i % 32];
                if (bank_base == REG_ENABLE_BASE) enable_d[i] = pwdata[i % 32];
                if (bank_base == REG_PEND_BASE)   w1c[i]      = pwdata[i % 32];
            end
            // A new rising edge beats a simultaneous W1C of the same bit
            pend_d[i] = mode_q[i] ? ((pend_q[i] & ~w1c[i]) | (sync_lvl[i] & ~prev_q[i]))
                                  : sync_lvl[i];
        end
        // Switching mode discards whatever was latched under the old mode
        pend_d       = pend_d & ~(mode_q ^ mode_d);
        status_d     = pend_d & enable_d;
        status_event = |(status_d & ~status);
        fire         = (thr_q == '0) || (count_q >= thr_q) ||
                       ((tmo_q != '0) && (timer_q >= tmo_q));
    end

    // Claim outputs track the status that will be visible after this edge
    periph_irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
        .req   (status_d),
        .valid (enc_valid),
        .id    (enc_id)
    );

    // Input synchroniser chain plus the previous-level flop for edge detection
    always_ff @(posedge clk_apb or negedge rst_apb_n) begin
        if (!rst_apb_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= src_irq;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_lvl;
        end
    end

    // Software-visible register state
    always_ff @(posedge clk_apb or negedge rst_apb_n) begin
        if (!rst_apb_n) begin
            mode_q   <= '0;
            enable_q <= '0;
            pend_q   <= '0;
            thr_q    <= '0;
            tmo_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            enable_q <= enable_d;
            pend_q   <= pend_d;
            if (wr_en && reg_addr == REG_COAL_CFG) begin
                thr_q <= pwdata[COAL_THR_LSB +: CNT_W];
                tmo_q <= pwdata[COAL_TMO_LSB +: TMO_W];
            end
        end
    end

    // Coalescing: count events and wait time, raise irq_out, drop it once status drains
    always_ff @(posedge clk_apb or negedge rst_apb_n) begin
        if (!rst_apb_n) begin
            irq_out <= 1'b0;
            count_q <= '0;
            timer_q <= '0;
        end else if (irq_out && !status_any) begin
            irq_out <= 1'b0;
            count_q <= '0;
            timer_q <= '0;
        end else begin
            if (status_event && count_q != CNT_MAX) count_q <= count_q + CNT_W'(1);
            if (status_any && !irq_out && timer_q != TMR_MAX) timer_q <= timer_q + TMO_W'(1);
            if (status_any && fire) irq_out <= 1'b1;
        end
    end

    // Registered claim information, independent of coalescing
    always_ff @(posedge clk_apb or negedge rst_apb_n) begin
        if (!rst_apb_n) begin
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else begin
            irq_valid <= enc_valid;
            irq_id    <= enc_id;
        end
    end

endmodule

// File: tb/tb_periph_irq_ctrl.sv
// tb/tb_periph_irq_ctrl.sv - self-checking bench for periph_irq_ctrl with a behavioural reference model
module tb_periph_irq_ctrl;

    localparam int NS = 64;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    paddr = '0;
    logic          pwrite = 1'b0;
    logic [31:0]   pwdata = '0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic [31:0]   prdata;
    logic          pready, pslverr;
    logic [NS-1:0] src = '0;
    logic          irq_out, irq_valid;
    logic [7:0]    irq_id;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit [NS-1:0] m_pipe [3];
    bit [NS-1:0] m_mode, m_en, m_pend;
    int          m_thr, m_tmo, m_cnt, m_tmr, m_id;
    bit          m_irq, m_valid;

    always #5 clk = ~clk;

    periph_irq_ctrl #(
        .NUM_SRC(NS), .SYNC_STAGES(2), .APB_AW(8), .APB_DW(32), .CNT_W(8), .TMO_W(16)
    ) dut (
        .clk_apb(clk), .rst_apb_n(rst_n), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .src_irq(src), .irq_out(irq_out), .irq_valid(irq_valid), .irq_id(irq_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int s = 0; s < 3; s++) m_pipe[s] = '0;
        m_mode = '0; m_en = '0; m_pend = '0;
        m_thr = 0; m_tmo = 0; m_cnt = 0; m_tmr = 0; m_id = 0;
        m_irq = 0; m_valid = 0;
    endfunction

    // kind: 0 RAW 1 MODE 2 ENABLE 3 PEND 4 STATUS 5 CLAIM 6 COAL_CFG 7 COAL_STAT
    function automatic void m_decode(input logic [7:0] a, input bit wr,
                                     output int kind, output int word, output bit err);
        int off;
        off  = int'(a) & 'hFC;
        kind = -1; word = 0; err = 1;
        if (off < 'hA0) begin
            kind = off / 32; word = (off % 32) / 4; err = (word >= NW);
        end else if (off == 'hA0) begin kind = 5; err = 0; end
        else if (off == 'hA4) begin kind = 6; err = 0; end
        else if (off == 'hA8) begin kind = 7; err = 0; end
        if (!err && wr && (kind == 0 || kind == 4 || kind == 5 || kind == 7)) err = 1;
    endfunction

    function automatic void m_read(input logic [7:0] a, input bit wr,
                                   output logic [31:0] d, output logic e);
        int kind, word;
        bit err;
        m_decode(a, wr, kind, word, err);
        d = '0; e = err;
        if (!err && !wr) begin
            case (kind)
                0: d = 32'(m_pipe[1] >> (32 * word));
                1: d = 32'(m_mode >> (32 * word));
                2: d = 32'(m_en >> (32 * word));
                3: d = 32'(m_pend >> (32 * word));
                4: d = 32'((m_pend & m_en) >> (32 * word));
                5: d = {m_valid, 23'b0, 8'(m_id)};
                6: d = 32'(m_thr) | (32'(m_tmo) << 16);
                default: d = 32'(m_cnt) | (32'(m_tmr) << 16);
            endcase
        end
    endfunction

    // One clock edge of the specified behaviour, from bench-side inputs only
    function automatic void m_step();
        bit [NS-1:0] raw, prv, st_old, st_new, pend_n, mode_n, en_n, w1c;
        int kind, word, thr_n, tmo_n;
        bit err, fire;
        if (!rst_n) begin m_reset(); return; end
        raw = m_pipe[1]; prv = m_pipe[2]; st_old = m_pend & m_en;
        mode_n = m_mode; en_n = m_en; w1c = '0; thr_n = m_thr; tmo_n = m_tmo;
        if (psel && penable && pwrite) begin
            m_decode(paddr, 1, kind, word, err);
            if (!err) begin
                case (kind)
                    1: mode_n[word*32 +: 32] = pwdata;
                    2: en_n[word*32 +: 32]   = pwdata;
                    3: w1c[word*32 +: 32]    = pwdata;
                    6: begin thr_n = int'(pwdata[7:0]); tmo_n = int'(pwdata[31:16]); end
                    default: ;
                endcase
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (mode_n[i] != m_mode[i]) pend_n[i] = 0;
            else if (m_mode[i])         pend_n[i] = (m_pend[i] && !w1c[i]) || (raw[i] && !prv[i]);
            else                        pend_n[i] = raw[i];
        end
        st_new = pend_n & en_n;
        if (m_irq && st_old == 0) begin
            m_irq = 0; m_cnt = 0; m_tmr = 0;
        end else begin
            fire = (st_old != 0) && (m_thr == 0 || m_cnt >= m_thr || (m_tmo != 0 && m_tmr >= m_tmo));
            if ((st_new & ~st_old) != 0 && m_cnt < 255) m_cnt++;
            if (st_old != 0 && !m_irq && m_tmr < 65535) m_tmr++;
            if (fire) m_irq = 1;
        end
        m_valid = (st_new != 0);
        m_id = 0;
        for (int i = NS - 1; i >= 0; i--) if (st_new[i]) m_id = i;
        m_mode = mode_n; m_en = en_n; m_pend = pend_n; m_thr = thr_n; m_tmo = tmo_n;
        m_pipe[2] = m_pipe[1]; m_pipe[1] = m_pipe[0]; m_pipe[0] = src;
    endfunction

    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
        check("outs", 32'({irq_out, irq_valid, irq_id}), 32'({m_irq, m_valid, 8'(m_id)}));
    endtask

    task automatic apb(input logic [7:0] a, input bit wr, input logic [31:0] d, output logic [31:0] rd);
        logic [31:0] exp_d;
        logic        exp_e;
        paddr = a; pwrite = wr; pwdata = d; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1;
        #1;
        m_read(a, wr, exp_d, exp_e);
        check("prdata", prdata, exp_d);
        check("pslverr", 32'(pslverr), 32'(exp_e));
        check("pready", 32'(pready), 32'd1);
        rd = prdata;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        apb(a, 1'b1, d, dummy);
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] rd);
        apb(a, 1'b0, 32'h0, rd);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_outs", 32'({irq_out, irq_valid, irq_id, pslverr}), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        m_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  addrs [13];
        int          n;

        addrs = '{8'h00, 8'h04, 8'h20, 8'h24, 8'h40, 8'h44, 8'h60, 8'h64,
                  8'h80, 8'h84, 8'hA0, 8'hA4, 8'hA8};
        m_reset();
        @(negedge clk);
        do_reset();

        // Reset values and error responses
        foreach (addrs[j]) begin
            apb_rd(addrs[j], rd);
            check("reset_read", rd, 32'd0);
        end
        apb_wr(8'h00, 32'hDEADBEEF);
        apb_rd(8'h00, rd);
        check("raw_after_ro_write", rd, 32'd0);
        apb_rd(8'hAC, rd);
        apb_rd(8'h08, rd);
        apb_wr(8'hA0, 32'hFFFFFFFF);

        // Level mode latency and claim
        apb_wr(8'h40, 32'hFFFFFFFF);
        apb_wr(8'h20, 32'h0);
        apb_wr(8'hA4, 32'h0);
        src[5] = 1'b1;
        tick(); tick();
        check("lvl_edge2_valid", 32'(irq_valid), 32'd0);
        tick();
        check("lvl_edge3", 32'({irq_valid, irq_out}), 32'b10);
        tick();
        check("lvl_edge4_irq", 32'(irq_out), 32'd1);
        apb_rd(8'hA0, rd);
        check("claim5", rd, 32'h80000005);
        src[5] = 1'b0;
        for (int j = 0; j < 6; j++) tick();
        check("lvl_drop", 32'(irq_out), 32'd0);

        // Edge mode: latch, set-beats-W1C, then W1C alone
        apb_wr(8'h20, 32'h200);
        src[9] = 1'b1; tick(); src[9] = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        apb_rd(8'h60, rd);
        check("edge_latched", rd & 32'h200, 32'h200);
        src[9] = 1'b1; tick();
        apb_wr(8'h60, 32'h200);
        apb_rd(8'h60, rd);
        check("set_beats_w1c", rd & 32'h200, 32'h200);
        apb_wr(8'h60, 32'h200);
        check("w1c_valid", 32'({irq_valid, irq_out}), 32'b01);
        tick();
        check("w1c_irq_drop", 32'(irq_out), 32'd0);

        // Priority between two edge sources
        apb_wr(8'h20, 32'h208);
        apb_wr(8'h24, 32'h100);
        apb_wr(8'h44, 32'hFFFFFFFF);
        src[3] = 1'b1; src[40] = 1'b1;
        tick(); tick(); tick();
        check("prio_id3", 32'(irq_id), 32'd3);
        src[3] = 1'b0; src[40] = 1'b0;
        apb_wr(8'h60, 32'h8);
        apb_rd(8'hA0, rd);
        check("claim40", rd, 32'h80000028);
        apb_wr(8'h64, 32'h100);
        tick(); tick();

        // Count threshold 3
        apb_wr(8'h20, 32'h21E);
        apb_wr(8'hA4, 32'h3);
        src[1] = 1'b1;
        for (int j = 0; j < 6; j++) tick();
        check("thr_ev1", 32'(irq_out), 32'd0);
        src[2] = 1'b1;
        for (int j = 0; j < 6; j++) tick();
        check("thr_ev2", 32'(irq_out), 32'd0);
        src[4] = 1'b1;
        tick(); tick(); tick();
        check("thr_ev3_same", 32'(irq_out), 32'd0);
        tick();
        check("thr_ev3_next", 32'(irq_out), 32'd1);
        src = '0;
        tick(); tick();
        apb_wr(8'h60, 32'hFFFFFFFF);
        tick(); tick();
        apb_rd(8'hA8, rd);
        check("coal_stat_clear", rd, 32'd0);

        // Timeout 100 with threshold 8
        apb_wr(8'hA4, (32'd100 << 16) | 32'd8);
        src[1] = 1'b1;
        n = 0;
        while (!irq_valid && n < 20) begin tick(); n++; end
        check("tmo_valid_seen", 32'(irq_valid), 32'd1);
        n = 0;
        while (!irq_out && n < 200) begin tick(); n++; end
        check("tmo_cycles", 32'(n), 32'd101);
        src[1] = 1'b0;
        apb_wr(8'h60, 32'h2);
        tick(); tick(); tick();
        src[2] = 1'b1;
        for (int j = 0; j < 50; j++) tick();
        apb_rd(8'hA8, rd);
        do_reset();
        apb_rd(8'hA4, rd);
        check("cfg_after_reset", rd, 32'd0);
        apb_rd(8'hA8, rd);
        check("stat_after_reset", rd, 32'd0);

        // Randomised traffic against the model
        apb_wr(8'h20, $urandom);
        apb_wr(8'h24, $urandom);
        apb_wr(8'h40, $urandom);
        apb_wr(8'h44, $urandom);
        apb_wr(8'hA4, (32'($urandom_range(0, 20)) << 16) | 32'($urandom_range(0, 4)));
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 2) == 0) src[$urandom_range(0, NS - 1)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: apb_wr(8'h60 + 8'(4 * $urandom_range(0, 1)), $urandom);
                    1: apb_rd(8'($urandom_range(0, 255)), rd);
                    2: apb_wr(8'($urandom_range(0, 255)), $urandom);
                    default: apb_rd(8'hA8, rd);
                endcase
            end else begin
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
